// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage (if_fetch / if_fifo).
package if_fetch_pkg;
  localparam int unsigned InstAddrBus = 16;
  localparam int unsigned InstBus     = 16;
  localparam logic [InstBus-1:0] NopInst = 16'h0000;

  // rst is active-low
  localparam logic RstEnable  = 1'b0;
  localparam logic RstDisable = 1'b1;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} if_state_t;
endpackage

// File: rtl/if_fifo.sv
// Prefetch FIFO of {pc, inst} pairs with push/pop/clear; the head entry is presented combinationally.
module if_fifo
  import if_fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [InstAddrBus-1:0] push_pc,
  input  logic [InstBus-1:0]     push_inst,
  output logic [InstAddrBus-1:0] head_pc,
  output logic [InstBus-1:0]     head_inst,
  output logic [CW-1:0]          count
);
  logic [InstAddrBus+InstBus-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_pc, push_inst};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst != RstDisable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign {head_pc, head_inst} = mem[rd_ptr];
endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: PC, single-outstanding imem req/ack, prefetch FIFO, stall and flush.
// Optional IF_FETCH_PERF_EN adds fetch_cnt/flush_cnt performance counters.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter logic [InstAddrBus-1:0] RESET_PC = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [InstAddrBus-1:0] imem_addr,
  input  logic                   imem_ack,
  input  logic [InstBus-1:0]     imem_rdata,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [InstAddrBus-1:0] flush_pc,
  output logic                   if_valid,
  output logic [InstAddrBus-1:0] if_pc,
  output logic [InstBus-1:0]     if_inst
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [15:0]            fetch_cnt,
  output logic [15:0]            flush_cnt
`endif
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if_state_t state, state_next;
  logic [InstAddrBus-1:0] fetch_pc, fetch_pc_next, addr_next, head_pc;
  logic [InstBus-1:0]     head_inst;
  logic [CW-1:0]          count, count_next;
  logic                   push, pop, room;

  assign pop        = if_valid && !stall && !flush;
  assign push       = imem_ack && (state == REQ) && !flush;
  assign count_next = count + CW'(push) - CW'(pop);
  // Issue only when the slot is guaranteed, so the entry is claimed on ack.
  assign room       = count_next < DEPTH_C;

  if_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .clear     (flush),
    .push_pc   (imem_addr),
    .push_inst (imem_rdata),
    .head_pc   (head_pc),
    .head_inst (head_inst),
    .count     (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) state <= IDLE;
    else                  state <= state_next;
  end

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    addr_next     = imem_addr;
    if (flush) begin
      // An issued request cannot be withdrawn: wait out its ack in DRAIN.
      fetch_pc_next = flush_pc;
      unique case (state)
        REQ, DRAIN: state_next = imem_ack ? IDLE : DRAIN;
        default:    state_next = IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE: begin
          if (room) begin
            state_next = REQ;
            addr_next  = fetch_pc;
          end
        end
        REQ: begin
          if (imem_ack) begin
            fetch_pc_next = fetch_pc + 1'b1;
            if (room) addr_next  = fetch_pc + 1'b1;
            else      state_next = IDLE;
          end
        end
        DRAIN: begin
          if (imem_ack) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      fetch_pc  <= RESET_PC;
      imem_addr <= RESET_PC;
    end else begin
      fetch_pc  <= fetch_pc_next;
      imem_addr <= addr_next;
    end
  end

  always_comb begin
    imem_req = (state != IDLE);
    if_valid = (count != '0);
    if_pc    = if_valid ? head_pc : '0;
    if_inst  = if_valid ? head_inst : NopInst;
  end

`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pop)   fetch_cnt <= fetch_cnt + 1'b1;
      if (flush) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: behavioural imem with configurable latency and a scoreboard of expected pops.
`timescale 1ns/1ps
module tb_if_fetch;
  localparam logic [15:0] RST_PC = 16'hFFFE;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic [15:0] flush_pc;
  logic        if_valid;
  logic [15:0] if_pc;
  logic [15:0] if_inst;
`ifdef IF_FETCH_PERF_EN
  logic [15:0] fetch_cnt;
  logic [15:0] flush_cnt;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] expq[$];
  bit          mem_auto;
  bit          mem_block;
  logic [15:0] block_addr;
  int          mem_lat;
  int          mem_cnt;
  bit          popped;
  int          cyc = 0;

  always #5 clk = ~clk;

  if_fetch #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_inst    (if_inst)
`ifdef IF_FETCH_PERF_EN
    ,
    .fetch_cnt  (fetch_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  function automatic logic [15:0] inst_of(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic push_range(input logic [15:0] start, input int n);
    for (int i = 0; i < n; i++) expq.push_back(start + 16'(i));
  endtask

  // Evaluate the current cycle (memory response + scoreboard), then advance one clock.
  task automatic tick();
    logic [15:0] exp_pc;
    popped = 1'b0;
    if (mem_auto) begin
      if (imem_req && !(mem_block && imem_addr == block_addr)) begin
        if (mem_cnt >= mem_lat - 1) begin
          imem_ack   = 1'b1;
          imem_rdata = inst_of(imem_addr);
          mem_cnt    = 0;
        end else begin
          imem_ack = 1'b0;
          mem_cnt++;
        end
      end else begin
        imem_ack = 1'b0;
        if (!imem_req) mem_cnt = 0;
      end
    end
    if (if_valid && !stall && !flush) begin
      popped = 1'b1;
      n_cmp++;
      if (expq.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got pc=%h inst=%h, required no delivery", if_pc, if_inst);
      end else begin
        exp_pc = expq.pop_front();
        if (if_pc !== exp_pc || if_inst !== inst_of(exp_pc)) begin
          n_err++;
          $display("FAIL sb_pop: got pc=%h inst=%h, required pc=%h inst=%h",
                   if_pc, if_inst, exp_pc, inst_of(exp_pc));
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && expq.size() != 0; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0; stall = 1'b0; flush = 1'b0; flush_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    mem_auto = 1'b1; mem_block = 1'b0; block_addr = '0; mem_lat = 1; mem_cnt = 0;
    expq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; flush = 1'b0; flush_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b, required 0", imem_req); end
    n_cmp++; if (imem_addr !== RST_PC) begin n_err++; $display("FAIL rst_addr: got %h, required %h", imem_addr, RST_PC); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b, required 0", if_valid); end
    n_cmp++; if (if_pc !== 16'h0000) begin n_err++; $display("FAIL rst_pc: got %h, required 0000", if_pc); end
    n_cmp++; if (if_inst !== 16'h0000) begin n_err++; $display("FAIL rst_inst: got %h, required 0000", if_inst); end
`ifdef IF_FETCH_PERF_EN
    n_cmp++; if (fetch_cnt !== 16'h0000) begin n_err++; $display("FAIL rst_fetch_cnt: got %h, required 0000", fetch_cnt); end
    n_cmp++; if (flush_cnt !== 16'h0000) begin n_err++; $display("FAIL rst_flush_cnt: got %h, required 0000", flush_cnt); end
`endif
  endtask

  task automatic test_stream();
    int p;
    do_reset();
    push_range(RST_PC, 12);
    tick();
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL stream_first_req: got %b, required 1", imem_req); end
    n_cmp++; if (imem_addr !== RST_PC) begin n_err++; $display("FAIL stream_first_addr: got %h, required %h", imem_addr, RST_PC); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL stream_c2_valid: got %b, required 0", if_valid); end
    tick();
    n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL stream_c3_valid: got %b, required 1", if_valid); end
    p = 0;
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (imem_addr !== RST_PC + 16'(i + 1)) begin
        n_err++; $display("FAIL stream_addr: got %h, required %h", imem_addr, RST_PC + 16'(i + 1));
      end
      tick();
      if (popped) p++;
    end
    n_cmp++; if (p != 12) begin n_err++; $display("FAIL stream_rate: got %0d pops, required 12", p); end
    n_cmp++; if (expq.size() != 0) begin n_err++; $display("FAIL stream_left: got %0d pending, required 0", expq.size()); end
  endtask

  task automatic test_stall();
    int p;
    do_reset();
    push_range(RST_PC, 12);
    tick();
    stall = 1'b1;
    repeat (10) tick();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req: got %b, required 0", imem_req); end
    n_cmp++; if (imem_addr !== RST_PC + 16'd3) begin n_err++; $display("FAIL stall_addr: got %h, required %h", imem_addr, RST_PC + 16'd3); end
    n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid: got %b, required 1", if_valid); end
    n_cmp++; if (if_pc !== RST_PC) begin n_err++; $display("FAIL stall_head_pc: got %h, required %h", if_pc, RST_PC); end
    n_cmp++; if (if_inst !== inst_of(RST_PC)) begin n_err++; $display("FAIL stall_head_inst: got %h, required %h", if_inst, inst_of(RST_PC)); end
    stall = 1'b0;
    p = 0;
    repeat (4) begin tick(); if (popped) p++; end
    n_cmp++; if (p != 4) begin n_err++; $display("FAIL stall_b2b: got %0d pops, required 4", p); end
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL stall_resume_req: got %b, required 1", imem_req); end
    n_cmp++; if (imem_addr !== RST_PC + 16'd7) begin n_err++; $display("FAIL stall_resume_addr: got %h, required %h", imem_addr, RST_PC + 16'd7); end
    drain(40);
    n_cmp++; if (expq.size() != 0) begin n_err++; $display("FAIL stall_timeout: got %0d pending, required 0", expq.size()); end
  endtask

  task automatic test_latency();
    logic [15:0] cur;
    int run, last_pop;
    bit have_cur, have_pop;
    do_reset();
    mem_lat = 3;
    push_range(RST_PC, 5);
    tick();
    have_cur = 1'b0; have_pop = 1'b0; run = 0; cur = '0; last_pop = 0;
    for (int i = 0; i < 40 && expq.size() != 0; i++) begin
      if (imem_req) begin
        if (have_cur && imem_addr == cur) run++;
        else begin
          if (have_cur) begin
            n_cmp++;
            if (run != 3) begin n_err++; $display("FAIL lat_addr_hold: addr %h held %0d cycles, required 3", cur, run); end
          end
          cur = imem_addr; run = 1; have_cur = 1'b1;
        end
      end
      tick();
      if (popped) begin
        if (have_pop) begin
          n_cmp++;
          if (cyc - last_pop != 3) begin n_err++; $display("FAIL lat_pop_gap: got %0d cycles, required 3", cyc - last_pop); end
        end
        last_pop = cyc; have_pop = 1'b1;
      end
    end
    n_cmp++; if (expq.size() != 0) begin n_err++; $display("FAIL lat_timeout: got %0d pending, required 0", expq.size()); end
  endtask

  task automatic test_flush_outstanding();
    do_reset();
    mem_block = 1'b1;
    block_addr = RST_PC + 16'd5;
    push_range(RST_PC, 5);
    for (int i = 0; i < 20 && !(imem_req && imem_addr == block_addr); i++) tick();
    tick();
    n_cmp++; if (expq.size() != 0) begin n_err++; $display("FAIL fo_pre: got %0d pending, required 0", expq.size()); end
    flush = 1'b1; flush_pc = 16'h0040;
    tick();
    flush = 1'b0;
    expq.delete();
    push_range(16'h0040, 4);
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL fo_valid: got %b, required 0", if_valid); end
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL fo_drain_req: got %b, required 1", imem_req); end
    n_cmp++; if (imem_addr !== block_addr) begin n_err++; $display("FAIL fo_drain_addr: got %h, required %h", imem_addr, block_addr); end
    tick();
    mem_auto = 1'b0;
    imem_ack = 1'b1; imem_rdata = inst_of(block_addr);
    tick();
    imem_ack = 1'b0;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL fo_idle_req: got %b, required 0", imem_req); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL fo_drop: got %b, required 0", if_valid); end
    mem_auto = 1'b1; mem_block = 1'b0; mem_cnt = 0;
    tick();
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL fo_new_req: got %b, required 1", imem_req); end
    n_cmp++; if (imem_addr !== 16'h0040) begin n_err++; $display("FAIL fo_new_addr: got %h, required 0040", imem_addr); end
    drain(30);
    n_cmp++; if (expq.size() != 0) begin n_err++; $display("FAIL fo_timeout: got %0d pending, required 0", expq.size()); end
  endtask

  task automatic test_flush_ack();
    do_reset();
    push_range(RST_PC, 2);
    for (int i = 0; i < 20 && imem_addr != RST_PC + 16'd3; i++) tick();
    n_cmp++; if (expq.size() != 0) begin n_err++; $display("FAIL fa_pre: got %0d pending, required 0", expq.size()); end
    flush = 1'b1; flush_pc = 16'h0100;
    tick();
    flush = 1'b0;
    expq.delete();
    push_range(16'h0100, 4);
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL fa_valid: got %b, required 0", if_valid); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL fa_req: got %b, required 0", imem_req); end
`ifdef IF_FETCH_PERF_EN
    n_cmp++; if (flush_cnt !== 16'd1) begin n_err++; $display("FAIL fa_flush_cnt: got %h, required 0001", flush_cnt); end
`endif
    tick();
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL fa_new_req: got %b, required 1", imem_req); end
    n_cmp++; if (imem_addr !== 16'h0100) begin n_err++; $display("FAIL fa_new_addr: got %h, required 0100", imem_addr); end
    drain(30);
    n_cmp++; if (expq.size() != 0) begin n_err++; $display("FAIL fa_timeout: got %0d pending, required 0", expq.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_lat = 3;
    push_range(RST_PC, 1);
    for (int i = 0; i < 30 && !(if_valid && imem_req && imem_addr == RST_PC + 16'd2); i++) tick();
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rm_req: got %b, required 0", imem_req); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid: got %b, required 0", if_valid); end
    n_cmp++; if (imem_addr !== RST_PC) begin n_err++; $display("FAIL rm_addr: got %h, required %h", imem_addr, RST_PC); end
`ifdef IF_FETCH_PERF_EN
    n_cmp++; if (fetch_cnt !== 16'd0) begin n_err++; $display("FAIL rm_fetch_cnt: got %h, required 0000", fetch_cnt); end
`endif
    @(negedge clk);
    imem_ack = 1'b0; mem_cnt = 0; mem_lat = 1;
    expq.delete();
    push_range(RST_PC, 3);
    rst = 1'b1;
    tick();
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rm_restart_req: got %b, required 1", imem_req); end
    n_cmp++; if (imem_addr !== RST_PC) begin n_err++; $display("FAIL rm_restart_addr: got %h, required %h", imem_addr, RST_PC); end
    drain(20);
    n_cmp++; if (expq.size() != 0) begin n_err++; $display("FAIL rm_timeout: got %0d pending, required 0", expq.size()); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_auto = 1'b1; mem_block = 1'b0; block_addr = '0; mem_lat = 1; mem_cnt = 0;
    test_reset();
    test_stream();
    test_stall();
    test_latency();
    test_flush_outstanding();
    test_flush_ack();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
